// File: rtl/alu_pkg.sv
// Shared ALU definitions: bit-finder FSM states and pointer-width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    BF_IDLE,
    BF_SCAN,
    BF_DONE
  } bf_state_t;

  function automatic int bf_ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_finder_if.sv
// Request/result bundle between the ALU control FSM and the bit finder.
interface bit_finder_if #(
  parameter int N = 8
);
  logic         in_start;
  logic [N-1:0] in_a;
  logic         in_ack;
  logic         o_busy;
  logic         o_valid;
  logic [N-1:0] o_index;
  logic [N-1:0] o_out;
  logic         o_ERR;

  modport master (
    output in_start, in_a, in_ack,
    input  o_busy, o_valid, o_index, o_out, o_ERR
  );

  modport slave (
    input  in_start, in_a, in_ack,
    output o_busy, o_valid, o_index, o_out, o_ERR
  );
endinterface

// File: rtl/bit_finder.sv
// Serial lowest-set-bit finder: scans the latched operand LSB first, one bit
// per cycle, and returns the bit index plus the operand with that bit cleared.
module bit_finder
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  bit_finder_if.slave bus
);

  localparam int PW = bf_ptr_w(N);

  bf_state_t     state_q, state_d;
  logic [N-1:0]  op_q, op_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  index_q, index_d;
  logic [N-1:0]  out_q, out_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    index_d = index_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      BF_IDLE: begin
        if (bus.in_start) begin
          op_d    = bus.in_a;
          ptr_d   = '0;
          state_d = BF_SCAN;
        end
      end
      BF_SCAN: begin
        if (op_q[ptr_q]) begin
          index_d = N'(ptr_q);
          out_d   = op_q & ~(N'(1) << ptr_q);
          err_d   = 1'b0;
          state_d = BF_DONE;
        end else if (ptr_q == PW'(N - 1)) begin
          index_d = '0;
          out_d   = '0;
          err_d   = 1'b1;
          state_d = BF_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      BF_DONE: begin
        // Ack wins over a simultaneous start; the index/operand stay visible.
        if (bus.in_ack) begin
          err_d   = 1'b0;
          state_d = BF_IDLE;
        end
      end
      default: state_d = BF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BF_IDLE;
      op_q    <= '0;
      ptr_q   <= '0;
      index_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      index_q <= index_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_busy  = (state_q != BF_IDLE);
  assign bus.o_valid = (state_q == BF_DONE);
  assign bus.o_index = index_q;
  assign bus.o_out   = out_q;
  assign bus.o_ERR   = err_q;

endmodule

// File: tb/tb_bit_finder.sv
// Randomized scoreboard bench for bit_finder: stimulus queues expected
// results, a negedge monitor compares them when o_valid rises.
module tb_bit_finder;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_finder_if #(.N(N)) bus ();

  bit_finder #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0] a;
    int           idx;
    logic [N-1:0] out;
    logic         err;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: isolate the lowest set bit arithmetically, then take its log2.
  function automatic exp_t model(input logic [N-1:0] a, input int sc);
    exp_t         e;
    logic [N-1:0] iso;
    int           k;
    iso = a & (~a + 1'b1);
    e.a = a;
    e.start_cyc = sc;
    if (a == 0) begin
      e.idx = 0;
      e.out = '0;
      e.err = 1'b1;
      e.lat = N;
    end else begin
      k = 0;
      while ((iso >> k) != 1) k++;
      e.idx = k;
      e.out = a - iso;
      e.err = 1'b0;
      e.lat = k + 1;
    end
    return e;
  endfunction

  // Monitor
  logic prev_v = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.o_valid && !prev_v) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        $display("txn a=%02h idx=%0d out=%02h err=%0d lat=%0d", mon_e.a, bus.o_index,
                 bus.o_out, bus.o_ERR, cyc - mon_e.start_cyc - 1);
        check("index", bus.o_index, mon_e.idx);
        check("out", bus.o_out, mon_e.out);
        check("err", bus.o_ERR, mon_e.err);
        check("latency", cyc - mon_e.start_cyc - 1, mon_e.lat);
        if (!mon_e.err)
          check("round_trip", bus.o_out | (N'(1) << bus.o_index), mon_e.a);
      end
    end
    prev_v <= bus.o_valid;
  end

  task automatic run(input logic [N-1:0] a, input int hold, input bit disturb, input bit ack_start);
    exp_t m;
    int   n;
    m = model(a, 0);
    @(negedge clk);
    check("idle_before_start", bus.o_busy, 0);
    bus.in_a = a;
    bus.in_start = 1'b1;
    sb.push_back(model(a, cyc));
    @(negedge clk);
    bus.in_start = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 40) begin
      check("busy_in_scan", bus.o_busy, 1);
      if (disturb) begin
        bus.in_a = N'($urandom);
        bus.in_start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("valid_timeout", 0, 1);
      sb.delete();
      bus.in_start = 1'b0;
      return;
    end
    repeat (hold) begin
      if (disturb) begin
        bus.in_a = N'($urandom);
        bus.in_start = 1'b1;
      end
      @(negedge clk);
      check("hold_valid", bus.o_valid, 1);
      check("hold_index", bus.o_index, m.idx);
      check("hold_out", bus.o_out, m.out);
      check("hold_err", bus.o_ERR, m.err);
    end
    bus.in_start = ack_start;
    bus.in_ack = 1'b1;
    @(negedge clk);
    bus.in_ack = 1'b0;
    bus.in_start = 1'b0;
    check("ack_valid", bus.o_valid, 0);
    check("ack_busy", bus.o_busy, 0);
    check("ack_err_clr", bus.o_ERR, 0);
    check("ack_index_kept", bus.o_index, m.idx);
    check("ack_out_kept", bus.o_out, m.out);
    @(negedge clk);
    check("no_rescan", bus.o_busy, 0);
  endtask

  initial begin
    bus.in_start = 1'b0;
    bus.in_a = '0;
    bus.in_ack = 1'b0;
    #1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_index", bus.o_index, 0);
    check("rst_out", bus.o_out, 0);
    check("rst_err", bus.o_ERR, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(8'b0010_1000, 3, 1'b0, 1'b0);
    run(8'h00, 2, 1'b0, 1'b0);
    run(8'h01, 0, 1'b0, 1'b0);
    run(8'h80, 1, 1'b0, 1'b0);
    run(8'h5a, 3, 1'b1, 1'b1);
    run(8'hc0, 2, 1'b1, 1'b0);

    // Abort mid-scan: outputs must clear without waiting for a clock edge
    @(negedge clk);
    bus.in_a = 8'h80;
    bus.in_start = 1'b1;
    sb.push_back(model(8'h80, cyc));
    @(negedge clk);
    bus.in_start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.o_busy, 0);
    check("abort_valid", bus.o_valid, 0);
    check("abort_index", bus.o_index, 0);
    check("abort_out", bus.o_out, 0);
    check("abort_err", bus.o_ERR, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h80, 1, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      run(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run(8'h00, 0, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
